demux3out3b_buf: RTL and testbench

Registered 1-to-3 demultiplexer with per-destination holding slots: the write side of the three-way 3-bit select path feeding the multicycle datapath. A single 3-bit producer stream is steered by a 2-bit `control` code into one of three one-entry output slots. Each slot holds its value until its consumer acknowledges it. Unroutable codes are dropped and counted, so the producer never stalls on a bad selector.

---
 rtl/demux3out3b_buf_pkg.sv | 15 +
 rtl/demux3out3b_buf_slot.sv | 36 +++
 rtl/demux3out3b_buf.sv | 83 ++++++++
 tb/tb_demux3out3b_buf.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/demux3out3b_buf_pkg.sv
// Shared constants for the 1-to-3 registered demultiplexer: payload width,
// channel codes and slot count.
package demux3out3b_buf_pkg;

  localparam int DATA_W    = 3;
  localparam int NUM_SLOTS = 3;

  typedef enum logic [1:0] {
    CH1     = 2'd0,
    CH2     = 2'd1,
    CH3     = 2'd2,
    CH_NONE = 2'd3
  } channel_t;

endpackage

// File: rtl/demux3out3b_buf_slot.sv
// One-entry holding slot: captures d on load and keeps it until acknowledged.
// A load in the same cycle as an ack refills the slot without a bubble.
module demux_slot #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         ack,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         free
);

  logic [W-1:0] q_reg;
  logic         valid_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      q_reg     <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      q_reg     <= d;
      valid_reg <= 1'b1;
    end else if (ack) begin
      // data stays put; only the valid flag drops
      valid_reg <= 1'b0;
    end
  end

  assign q     = q_reg;
  assign valid = valid_reg;
  assign free  = ~valid_reg | ack;

endmodule

// File: rtl/demux3out3b_buf.sv
// Registered 1-to-3 demultiplexer: steers the producer stream into one of three
// holding slots by control code; code 3 is dropped and counted.
module demux3out3b_buf
  import demux3out3b_buf_pkg::*;
#(
  parameter int DATA_W = demux3out3b_buf_pkg::DATA_W,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [1:0]        control,
  output logic              in_ready,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [2:0]        out_valid,
  input  logic [2:0]        out_ack,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              drop_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_SLOTS-1:0] load;
  logic [NUM_SLOTS-1:0] free;
  logic [DATA_W-1:0]    slot_q [NUM_SLOTS];
  logic                 accept;
  logic                 drop;

  logic [CNT_W-1:0] drop_cnt_reg;
  logic             drop_err_reg;

  always_comb begin
    in_ready = 1'b1;
    case (control)
      CH1:     in_ready = free[0];
      CH2:     in_ready = free[1];
      CH3:     in_ready = free[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & (control == CH_NONE);

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign load[gi] = accept & (control == gi[1:0]);

      demux_slot #(.W(DATA_W)) u_slot (
        .clock (clock),
        .reset (reset),
        .load  (load[gi]),
        .ack   (out_ack[gi]),
        .d     (in_data),
        .q     (slot_q[gi]),
        .valid (out_valid[gi]),
        .free  (free[gi])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_reg <= '0;
      drop_err_reg <= 1'b0;
    end else if (drop) begin
      if (drop_cnt_reg != CNT_MAX) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
      drop_err_reg <= 1'b1;
    end
  end

  assign out1     = slot_q[0];
  assign out2     = slot_q[1];
  assign out3     = slot_q[2];
  assign drop_cnt = drop_cnt_reg;
  assign drop_err = drop_err_reg;

endmodule

// File: tb/tb_demux3out3b_buf.sv
// Self-checking bench for demux3out3b_buf: directed scenarios plus a random
// run, all compared against a slot-level behavioural model.
module tb_demux3out3b_buf;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] in_data;
  logic       in_valid;
  logic [1:0] control;
  logic       in_ready;
  logic [2:0] out1, out2, out3;
  logic [2:0] out_valid;
  logic [2:0] out_ack;
  logic [3:0] drop_cnt;
  logic       drop_err;

  demux3out3b_buf #(.DATA_W(3), .CNT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .control   (control),
    .in_ready  (in_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .drop_cnt  (drop_cnt),
    .drop_err  (drop_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // behavioural model: contents of each slot, its occupancy, drop bookkeeping
  logic [2:0] m_data [3];
  bit         m_full [4];
  int         m_drops;
  bit         m_err;
  bit         rdy_obs;
  bit         rdy_exp;

  function automatic logic [16:0] model_vec();
    return {m_data[0], m_data[1], m_data[2], m_full[2], m_full[1], m_full[0],
            4'(m_drops), m_err};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {out1, out2, out3, out_valid, drop_cnt, drop_err};
  endfunction

  // Drive one cycle, sample in_ready before the edge, advance the model.
  task automatic apply(input logic v, input logic [2:0] d, input logic [1:0] c,
                       input logic [2:0] a, input logic r);
    bit acc;
    in_valid = v; in_data = d; control = c; out_ack = a; reset = r;
    #2;
    rdy_obs = in_ready;
    rdy_exp = (c == 2'd3) || !m_full[c] || a[c];
    @(posedge clock);
    if (r) begin
      for (int k = 0; k < 3; k++) begin m_data[k] = 3'd0; m_full[k] = 0; end
      m_drops = 0; m_err = 0;
    end else begin
      acc = v && rdy_exp;
      for (int k = 0; k < 3; k++) begin
        if (acc && c == k[1:0]) begin m_data[k] = d; m_full[k] = 1; end
        else if (a[k]) m_full[k] = 0;
      end
      if (acc && c == 2'd3) begin
        if (m_drops < 15) m_drops++;
        m_err = 1;
      end
    end
    #1;
    reset = 1'b0; in_valid = 1'b0; out_ack = 3'b000;
  endtask

  task automatic test_reset();
    apply(1, 3'd1, 2'd0, 3'b000, 0);
    apply(1, 3'd2, 2'd1, 3'b000, 0);
    apply(1, 3'd4, 2'd2, 3'b000, 0);
    apply(1, 3'd0, 2'd3, 3'b000, 0);
    apply(0, 3'd0, 2'd0, 3'b000, 1);
    apply(0, 3'd0, 2'd0, 3'b000, 0);
    checks++;
    if (dut_vec() !== 17'd0) begin
      errors++; $display("FAIL reset_state got %h want %h", dut_vec(), 17'd0);
    end
  endtask

  task automatic test_fill_and_block();
    apply(1, 3'b101, 2'd0, 3'b000, 0);
    apply(1, 3'b011, 2'd1, 3'b000, 0);
    apply(1, 3'b110, 2'd2, 3'b000, 0);
    checks++;
    if ({out1, out2, out3, out_valid} !== {3'd5, 3'd3, 3'd6, 3'b111}) begin
      errors++; $display("FAIL fill got %h %h %h %b want 5 3 6 111", out1, out2, out3, out_valid);
    end
    apply(1, 3'b001, 2'd1, 3'b000, 0);
    checks++;
    if (rdy_obs !== 1'b0 || out2 !== 3'd3) begin
      errors++; $display("FAIL block_full got rdy=%b out2=%0d want rdy=0 out2=3", rdy_obs, out2);
    end
    apply(1, 3'b010, 2'd1, 3'b010, 0);
    checks++;
    if (rdy_obs !== 1'b1 || out2 !== 3'd2 || out_valid !== 3'b111) begin
      errors++; $display("FAIL ack_refill got rdy=%b out2=%0d v=%b want rdy=1 out2=2 v=111",
                         rdy_obs, out2, out_valid);
    end
  endtask

  task automatic test_independent();
    apply(0, 3'd0, 2'd0, 3'b100, 0);
    apply(1, 3'b111, 2'd2, 3'b000, 0);
    checks++;
    if (rdy_obs !== 1'b1 || out3 !== 3'd7 || out1 !== 3'd5 || out_valid !== 3'b111) begin
      errors++; $display("FAIL independent got rdy=%b out3=%0d out1=%0d v=%b want 1 7 5 111",
                         rdy_obs, out3, out1, out_valid);
    end
  endtask

  task automatic test_drop_saturate();
    int not_ready = 0;
    for (int i = 0; i < 20; i++) begin
      apply(1, 3'($urandom), 2'd3, 3'b000, 0);
      if (rdy_obs !== 1'b1) not_ready++;
    end
    checks++;
    if (not_ready != 0) begin
      errors++; $display("FAIL drop_ready got %0d stalled cycles want 0", not_ready);
    end
    checks++;
    if (drop_cnt !== 4'd15 || drop_err !== 1'b1) begin
      errors++; $display("FAIL drop_sat got cnt=%0d err=%b want cnt=15 err=1", drop_cnt, drop_err);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL drop_slots got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_back_to_back();
    apply(0, 3'd0, 2'd0, 3'b111, 0);
    for (int i = 0; i < 8; i++) begin
      apply(1, 3'(i), 2'd0, 3'b001, 0);
      checks++;
      if (rdy_obs !== 1'b1 || out1 !== 3'(i) || out_valid[0] !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d] got rdy=%b out1=%0d v0=%b want 1 %0d 1",
                           i, rdy_obs, out1, out_valid[0], i);
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    apply(1, 3'b101, 2'd1, 3'b000, 1);
    checks++;
    if (out2 !== 3'd0 || out_valid !== 3'b000 || drop_cnt !== 4'd0 || drop_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid got out2=%0d v=%b cnt=%0d err=%b want 0 000 0 0",
                         out2, out_valid, drop_cnt, drop_err);
    end
    apply(0, 3'd0, 2'd0, 3'b111, 0);
    checks++;
    if (dut_vec() !== 17'd0) begin
      errors++; $display("FAIL spurious_ack got %h want %h", dut_vec(), 17'd0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      apply(1'($urandom), 3'($urandom), 2'($urandom), 3'($urandom),
            ($urandom_range(0, 49) == 0));
      checks++;
      if (rdy_obs !== rdy_exp) begin
        errors++; $display("FAIL rand_ready[%0d] got %b want %b", i, rdy_obs, rdy_exp);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL rand_state[%0d] got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; control = '0; out_ack = '0;
    for (int k = 0; k < 3; k++) begin m_data[k] = 3'd0; m_full[k] = 0; end
    m_full[3] = 0; m_drops = 0; m_err = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_fill_and_block();
    test_independent();
    test_drop_saturate();
    test_back_to_back();
    test_reset_mid_transfer();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
